// File: rtl/dmem_access_sched_pkg.sv
// Shared types and constants for the DMem access scheduler: channel indices,
// latched burst command layout and the per-channel stream FSM states.
package dmem_access_sched_pkg;

  localparam int unsigned DMEM_ADDR_W = 10;
  localparam int unsigned DMEM_DATA_W = 32;
  localparam int unsigned DMEM_LEN_W  = 10;

  localparam int unsigned CH_LD1 = 0;
  localparam int unsigned CH_LD2 = 1;
  localparam int unsigned CH_ST1 = 2;
  localparam int unsigned CH_ST2 = 3;
  localparam int unsigned NUM_CH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StDrain
  } stream_state_e;

  typedef struct packed {
    logic [DMEM_ADDR_W-1:0] base;
    logic [DMEM_LEN_W-1:0]  stride;
    logic [DMEM_LEN_W-1:0]  len;
  } s_stream_cmd;

  // Next element address; wraps silently modulo the address space.
  function automatic logic [DMEM_ADDR_W-1:0] agen_step(input logic [DMEM_ADDR_W-1:0] addr,
                                                       input logic [DMEM_LEN_W-1:0]  stride);
    return addr + DMEM_ADDR_W'(stride);
  endfunction

endpackage

// File: rtl/dmem_stream_agen.sv
// One burst stream: latches a strided command, walks its addresses with a
// running accumulator and reports when it may compete for the SRAM.
module dmem_stream_agen
  import dmem_access_sched_pkg::*;
#(
  parameter bit IS_LOAD = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req,
  input  logic                   valid,
  input  s_stream_cmd            cmd,
  input  logic                   st_data_valid,
  input  logic                   issue,
  output logic                   ready,
  output logic                   grant,
  output logic                   eligible,
  output logic [DMEM_ADDR_W-1:0] addr
);

  stream_state_e          state_q;
  logic                   grant_q;
  logic [DMEM_ADDR_W-1:0] addr_q;
  logic [DMEM_LEN_W-1:0]  stride_q;
  logic [DMEM_LEN_W-1:0]  len_q;
  logic [DMEM_LEN_W-1:0]  k_q;
  logic                   last;

  assign last = (k_q == len_q - DMEM_LEN_W'(1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      k_q      <= '0;
    end else begin
      grant_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req && valid) begin
            grant_q  <= 1'b1;
            addr_q   <= cmd.base;
            stride_q <= cmd.stride;
            len_q    <= cmd.len;
            k_q      <= '0;
            // Zero-length bursts are acknowledged but never leave idle.
            if (cmd.len != '0) state_q <= StActive;
          end
        end
        StActive: begin
          if (issue) begin
            addr_q <= agen_step(addr_q, stride_q);
            k_q    <= k_q + DMEM_LEN_W'(1);
            if (last) state_q <= IS_LOAD ? StDrain : StIdle;
          end
        end
        StDrain: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ready    = (state_q == StIdle);
  assign grant    = grant_q;
  // The grant cycle itself never issues.
  assign eligible = (state_q == StActive) && !grant_q && (IS_LOAD || st_data_valid);
  assign addr     = addr_q;

endmodule

// File: rtl/dmem_access_sched.sv
// Schedules the Ld1/Ld2/St1/St2 strided bursts onto one single-port SRAM with a
// round-robin arbiter and a one-cycle load return pipeline.
module dmem_access_sched
  import dmem_access_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W,
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned LEN_W  = DMEM_LEN_W
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [3:0]             I_Req,
  input  logic [3:0]             I_Valid,
  input  logic [3:0][ADDR_W-1:0] I_Base,
  input  logic [3:0][LEN_W-1:0]  I_Stride,
  input  logic [3:0][LEN_W-1:0]  I_Length,
  output logic [3:0]             O_Ready,
  output logic [3:0]             O_Grant,
  input  logic [1:0][DATA_W-1:0] I_St_Data,
  input  logic [1:0]             I_St_Data_Valid,
  output logic [1:0]             O_St_Pop,
  output logic [1:0][DATA_W-1:0] O_Ld_Data,
  output logic [1:0]             O_Ld_Valid,
  output logic                   O_Mem_En,
  output logic                   O_Mem_We,
  output logic [ADDR_W-1:0]      O_Mem_Addr,
  output logic [DATA_W-1:0]      O_Mem_WData,
  input  logic [DATA_W-1:0]      I_Mem_RData
);

  logic [NUM_CH-1:0]                  elig;
  logic [NUM_CH-1:0]                  issue;
  logic [NUM_CH-1:0]                  st_dv;
  logic [NUM_CH-1:0][DMEM_ADDR_W-1:0] ch_addr;
  logic [1:0]                         ptr_q;
  logic [1:0]                         win_idx;
  logic [1:0]                         cand;
  logic                               win_found;
  logic                               is_store;
  logic [1:0]                         ld_valid_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    s_stream_cmd cmd;
    assign cmd = '{base: I_Base[i], stride: I_Stride[i], len: I_Length[i]};

    if (i >= CH_ST1) begin : g_st
      assign st_dv[i] = I_St_Data_Valid[i-CH_ST1];
    end else begin : g_ld
      assign st_dv[i] = 1'b0;
    end

    dmem_stream_agen #(
      .IS_LOAD(i < CH_ST1)
    ) u_agen (
      .clock        (clock),
      .reset        (reset),
      .req          (I_Req[i]),
      .valid        (I_Valid[i]),
      .cmd          (cmd),
      .st_data_valid(st_dv[i]),
      .issue        (issue[i]),
      .ready        (O_Ready[i]),
      .grant        (O_Grant[i]),
      .eligible     (elig[i]),
      .addr         (ch_addr[i])
    );
  end

  // First eligible channel at or after the pointer wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    issue = '0;
    if (win_found) issue[win_idx] = 1'b1;
  end

  assign is_store    = win_found && (win_idx >= 2'(CH_ST1));
  assign O_Mem_En    = win_found;
  assign O_Mem_We    = is_store;
  assign O_Mem_Addr  = win_found ? ch_addr[win_idx] : '0;
  // Store channels sit at indices 2/3, so the low index bit selects St1/St2 data.
  assign O_Mem_WData = is_store ? I_St_Data[win_idx[0]] : '0;
  assign O_St_Pop    = issue[CH_ST2:CH_ST1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      ld_valid_q <= '0;
    end else begin
      if (win_found) ptr_q <= win_idx + 2'd1;
      ld_valid_q <= issue[CH_LD2:CH_LD1];
    end
  end

  assign O_Ld_Valid = ld_valid_q;

  always_comb begin
    O_Ld_Data = '0;
    for (int l = 0; l < 2; l++) begin
      if (ld_valid_q[l]) O_Ld_Data[l] = I_Mem_RData;
    end
  end

endmodule

// File: tb/tb_dmem_access_sched.sv
// Scoreboard bench for dmem_access_sched: a queue-based reference model predicts
// SRAM accesses, load returns, grants and ready; a separate monitor checks them.
module tb_dmem_access_sched;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int LW  = 10;
  localparam int BIG = 32'h3fff_ffff;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [3:0]        I_Req = '0;
  logic [3:0]        I_Valid = '0;
  logic [3:0][AW-1:0] I_Base = '0;
  logic [3:0][LW-1:0] I_Stride = '0;
  logic [3:0][LW-1:0] I_Length = '0;
  logic [3:0]        O_Ready;
  logic [3:0]        O_Grant;
  logic [1:0][DW-1:0] I_St_Data = '0;
  logic [1:0]        I_St_Data_Valid = '0;
  logic [1:0]        O_St_Pop;
  logic [1:0][DW-1:0] O_Ld_Data;
  logic [1:0]        O_Ld_Valid;
  logic              O_Mem_En;
  logic              O_Mem_We;
  logic [AW-1:0]     O_Mem_Addr;
  logic [DW-1:0]     O_Mem_WData;
  logic [DW-1:0]     I_Mem_RData = '0;

  dmem_access_sched dut (
    .clock          (clock),
    .reset          (reset),
    .I_Req          (I_Req),
    .I_Valid        (I_Valid),
    .I_Base         (I_Base),
    .I_Stride       (I_Stride),
    .I_Length       (I_Length),
    .O_Ready        (O_Ready),
    .O_Grant        (O_Grant),
    .I_St_Data      (I_St_Data),
    .I_St_Data_Valid(I_St_Data_Valid),
    .O_St_Pop       (O_St_Pop),
    .O_Ld_Data      (O_Ld_Data),
    .O_Ld_Valid     (O_Ld_Valid),
    .O_Mem_En       (O_Mem_En),
    .O_Mem_We       (O_Mem_We),
    .O_Mem_Addr     (O_Mem_Addr),
    .O_Mem_WData    (O_Mem_WData),
    .I_Mem_RData    (I_Mem_RData)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // SRAM fixture: single port, one-cycle read latency.
  logic [DW-1:0] sram [1024];
  always @(posedge clock) begin
    if (O_Mem_En) begin
      if (O_Mem_We) sram[O_Mem_Addr] <= O_Mem_WData;
      else I_Mem_RData <= sram[O_Mem_Addr];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [1:0]    ch;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;
  typedef struct packed {
    logic [3:0] ready;
    logic [3:0] grant;
  } ctl_t;

  bit            run = 1'b0;
  int unsigned   pend[4][$];
  int            elig_from[4];
  int            ready_at[4];
  int            rr = 0;
  logic [3:0]    grant_nxt = '0;
  logic [DW-1:0] ref_mem [1024];
  acc_t          acc_q[$];
  ctl_t          ctl_q[$];
  logic [DW-1:0] ld_q0[$];
  logic [DW-1:0] ld_q1[$];

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      pend[c].delete();
      elig_from[c] = 0;
      ready_at[c]  = 0;
    end
    rr = 0;
    grant_nxt = '0;
    acc_q.delete();
    ctl_q.delete();
    ld_q0.delete();
    ld_q1.delete();
  endtask

  task automatic model_cycle();
    logic [3:0] r;
    int win;
    acc_t a;
    ctl_t ct;
    for (int c = 0; c < 4; c++) r[c] = (cyc >= ready_at[c]);
    ct.ready = r;
    ct.grant = grant_nxt;
    ctl_q.push_back(ct);
    grant_nxt = '0;
    win = -1;
    for (int i = 0; i < 4; i++) begin
      int c = (rr + i) % 4;
      if (win < 0 && pend[c].size() > 0 && cyc >= elig_from[c] &&
          (c < 2 || I_St_Data_Valid[c-2])) win = c;
    end
    if (win >= 0) begin
      a.ch   = 2'(win);
      a.addr = AW'(pend[win].pop_front());
      if (win >= 2) begin
        a.we = 1'b1;
        a.wdata = I_St_Data[win-2];
        ref_mem[a.addr] = a.wdata;
      end else begin
        a.we = 1'b0;
        a.wdata = '0;
        if (win == 0) ld_q0.push_back(ref_mem[a.addr]);
        else ld_q1.push_back(ref_mem[a.addr]);
      end
      acc_q.push_back(a);
      if (pend[win].size() == 0) ready_at[win] = cyc + ((win < 2) ? 2 : 1);
      rr = (win + 1) % 4;
    end
    for (int c = 0; c < 4; c++) begin
      if (r[c] && I_Req[c] && I_Valid[c]) begin
        grant_nxt[c] = 1'b1;
        if (I_Length[c] != 0) begin
          for (int unsigned k = 0; k < I_Length[c]; k++)
            pend[c].push_back((int'(I_Base[c]) + k * int'(I_Stride[c])) % 1024);
          elig_from[c] = cyc + 2;
          ready_at[c]  = BIG;
        end
      end
    end
  endtask

  function automatic bit model_idle();
    for (int c = 0; c < 4; c++)
      if (pend[c].size() != 0 || cyc < ready_at[c]) return 1'b0;
    return 1'b1;
  endfunction

  initial forever begin
    @(negedge clock);
    if (run) model_cycle();
  end

  // ---------------- monitor ----------------
  int            en_cnt = 0;
  int            pop_cnt[2];
  logic [DW-1:0] ld0_last = '0;
  logic [AW-1:0] st1_log[$];

  initial forever begin
    acc_t a;
    ctl_t ct;
    logic [1:0] ep;
    logic [DW-1:0] ed;
    @(negedge clock);
    #1;
    if (run) begin
      if (ctl_q.size() == 0) begin
        total++; bad++;
        $display("FAIL ctl_queue: got empty expected entry (cycle %0d)", cyc);
      end else begin
        ct = ctl_q.pop_front();
        chk("ready", 64'(O_Ready), 64'(ct.ready));
        chk("grant", 64'(O_Grant), 64'(ct.grant));
      end
      if (O_Mem_En) begin
        en_cnt++;
        if (O_St_Pop[0]) begin pop_cnt[0]++; st1_log.push_back(O_Mem_Addr); end
        if (O_St_Pop[1]) pop_cnt[1]++;
        if (acc_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_access: got addr %0h expected none (cycle %0d)",
                   O_Mem_Addr, cyc);
        end else begin
          a = acc_q.pop_front();
          chk("mem_we", 64'(O_Mem_We), 64'(a.we));
          chk("mem_addr", 64'(O_Mem_Addr), 64'(a.addr));
          if (a.we) chk("mem_wdata", 64'(O_Mem_WData), 64'(a.wdata));
          ep = a.we ? ((a.ch == 2'd3) ? 2'b10 : 2'b01) : 2'b00;
          chk("st_pop", 64'(O_St_Pop), 64'(ep));
        end
      end else begin
        if (acc_q.size() != 0) begin
          a = acc_q.pop_front();
          total++; bad++;
          $display("FAIL missing_access: got none expected addr %0h (cycle %0d)", a.addr, cyc);
        end
        chk("st_pop_idle", 64'(O_St_Pop), 64'(0));
      end
      for (int l = 0; l < 2; l++) begin
        if (O_Ld_Valid[l]) begin
          if ((l == 0 ? ld_q0.size() : ld_q1.size()) == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ld_valid%0d: got data %0h expected none (cycle %0d)",
                     l, O_Ld_Data[l], cyc);
          end else begin
            ed = (l == 0) ? ld_q0.pop_front() : ld_q1.pop_front();
            chk(l == 0 ? "ld1_data" : "ld2_data", 64'(O_Ld_Data[l]), 64'(ed));
            if (l == 0) ld0_last = O_Ld_Data[0];
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  int            st_mode[2];   // 0 always valid, 1 random, 2 withheld
  bit            st_fix_en[2];
  logic [DW-1:0] st_fix_val[2];

  initial forever begin
    @(posedge clock);
    #1;
    for (int s = 0; s < 2; s++) begin
      I_St_Data[s] = st_fix_en[s] ? st_fix_val[s] : $urandom;
      case (st_mode[s])
        0: I_St_Data_Valid[s] = 1'b1;
        1: I_St_Data_Valid[s] = 1'($urandom_range(1));
        default: I_St_Data_Valid[s] = 1'b0;
      endcase
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_cmd(int ch, int base, int stride, int len);
    I_Req[ch]    = 1'b1;
    I_Valid[ch]  = 1'b1;
    I_Base[ch]   = AW'(base);
    I_Stride[ch] = LW'(stride);
    I_Length[ch] = LW'(len);
  endtask

  task automatic fire();
    step(1);
    I_Req   = '0;
    I_Valid = '0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (!model_idle() && n < budget) begin
      step(1);
      n++;
    end
    if (n >= budget) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy expected idle within %0d cycles", budget);
    end
    step(3);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    st_mode = '{0, 0};
    st_fix_en = '{0, 0};
    st_fix_val = '{0, 0};
    pop_cnt = '{0, 0};
    model_reset();

    // Reset values
    #1;
    chk("rst_ready", 64'(O_Ready), 64'hf);
    chk("rst_grant", 64'(O_Grant), 64'h0);
    chk("rst_mem_en", 64'(O_Mem_En), 64'h0);
    chk("rst_ld_valid", 64'(O_Ld_Valid), 64'h0);
    chk("rst_mem_addr", 64'(O_Mem_Addr), 64'h0);
    step(2);
    reset = 1'b0;
    run = 1'b1;
    step(2);

    // Single load burst
    set_cmd(0, 'h010, 2, 4);
    fire();
    wait_idle(50);

    // All four channels at once
    pop_cnt = '{0, 0};
    set_cmd(0, 'h100, 1, 2);
    set_cmd(1, 'h200, 1, 2);
    set_cmd(2, 'h300, 1, 2);
    set_cmd(3, 'h380, 1, 2);
    fire();
    wait_idle(50);
    chk("st1_pops", 64'(pop_cnt[0]), 64'd2);
    chk("st2_pops", 64'(pop_cnt[1]), 64'd2);

    // Wrap-around store
    st1_log.delete();
    set_cmd(2, 'h3fe, 3, 3);
    fire();
    wait_idle(50);
    chk("wrap_count", 64'(st1_log.size()), 64'd3);
    if (st1_log.size() == 3) begin
      chk("wrap_a0", 64'(st1_log[0]), 64'h3fe);
      chk("wrap_a1", 64'(st1_log[1]), 64'h001);
      chk("wrap_a2", 64'(st1_log[2]), 64'h004);
    end

    // Zero-length command
    en_cnt = 0;
    set_cmd(3, 'h050, 1, 0);
    fire();
    step(5);
    chk("len0_no_access", 64'(en_cnt), 64'd0);

    // Store then load same address
    st_fix_en[0] = 1'b1;
    st_fix_val[0] = 32'hdeadbeef;
    set_cmd(2, 'h020, 1, 1);
    fire();
    wait_idle(50);
    st_fix_en[0] = 1'b0;
    set_cmd(0, 'h020, 1, 1);
    fire();
    wait_idle(50);
    chk("raw_deadbeef", 64'(ld0_last), 64'hdeadbeef);

    // St1 data withheld while another channel proceeds
    st_mode[0] = 2;
    set_cmd(2, 'h0c0, 1, 3);
    set_cmd(1, 'h0c0, 1, 4);
    fire();
    step(3);
    st_mode[0] = 0;
    wait_idle(50);

    // Randomized traffic
    st_mode = '{1, 1};
    for (int it = 0; it < 300; it++) begin
      I_Req = '0;
      I_Valid = '0;
      if ($urandom_range(2) == 0) begin
        for (int c = 0; c < 4; c++) begin
          if ($urandom_range(1) == 1) begin
            set_cmd(c, int'($urandom_range(1023)), int'($urandom_range(1023)),
                    int'($urandom_range(7)));
            if ($urandom_range(3) == 0) I_Valid[c] = 1'b0;
          end
        end
      end
      step(1);
    end
    I_Req = '0;
    I_Valid = '0;
    wait_idle(2000);

    // Reset mid-burst
    st_mode = '{0, 0};
    set_cmd(0, 'h3a0, 1, 20);
    set_cmd(2, 'h3c0, 1, 20);
    fire();
    step(6);
    run = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_ready", 64'(O_Ready), 64'hf);
    chk("midrst_mem_en", 64'(O_Mem_En), 64'h0);
    chk("midrst_ld_valid", 64'(O_Ld_Valid), 64'h0);
    chk("midrst_st_pop", 64'(O_St_Pop), 64'h0);
    chk("midrst_grant", 64'(O_Grant), 64'h0);
    model_reset();
    step(2);
    reset = 1'b0;
    run = 1'b1;
    step(10);

    chk("acc_q_drained", 64'(acc_q.size()), 64'd0);
    chk("ld1_q_drained", 64'(ld_q0.size()), 64'd0);
    chk("ld2_q_drained", 64'(ld_q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
